// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch controller:
//   - state_e      : FSM state encoding (IDLE, RUN, PAUSE, DONE)
//   - BCD_TENS_MAX : largest tens digit of a seconds/minutes field (5)
//   - BCD_UNIT_MAX : largest units digit of a BCD field (9)
//   - at_limit()   : true when the fed-back count reads 59:59
// No ports (package).
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_TENS_MAX = 4'd5;
  localparam logic [3:0] BCD_UNIT_MAX = 4'd9;

  // True when the external counter shows mm:ss = 59:59.
  function automatic logic at_limit(
    input logic [3:0] sec_unit,
    input logic [3:0] sec_tens,
    input logic [3:0] min_unit,
    input logic [3:0] min_tens
  );
    return (sec_unit == BCD_UNIT_MAX) && (sec_tens == BCD_TENS_MAX) &&
           (min_unit == BCD_UNIT_MAX) && (min_tens == BCD_TENS_MAX);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw mechanical button:
//   two-flop synchronizer -> level debouncer -> rising-edge press pulse.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive synchronized
// samples differ from the currently accepted level. The press pulse is
// registered together with the accepted level, so a clean edge on btn_raw
// shows up on press DEBOUNCE_CYCLES+2 clock edges later.
//
// Ports:
//   clk     in   1  clock
//   rst_n   in   1  asynchronous active-low reset
//   btn_raw in   1  raw active-high button, asynchronous to clk
//   press   out  1  one-cycle pulse when a debounced 0->1 change is accepted
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  // The counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (sync2_q == stable_q) begin
      // Any sample agreeing with the accepted level restarts the run.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // This is the DEBOUNCE_CYCLES-th differing sample in a row.
      stable_d = sync2_q;
      cnt_d    = '0;
      press_d  = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Control path of an mm:ss stopwatch. Debounces the start/stop and clear
// buttons, runs the IDLE/RUN/PAUSE/DONE state machine, divides clk_50mhz down
// to a one-cycle count-advance pulse and stops the count at 59:59.
//
// Parameters:
//   CLK_FREQ         clk_50mhz cycles per timer second
//   DEBOUNCE_CYCLES  stable-level cycles needed to accept a button change
//
// Ports:
//   clk_50mhz  in   1  system clock, all state changes on its rising edge
//   reset_n    in   1  asynchronous active-low reset
//   btn_start  in   1  raw start/stop button
//   btn_clear  in   1  raw clear button
//   sec_unit, sec_tens, min_unit, min_tens  in  4 each  BCD count fed back
//   tick_1hz   out  1  one-cycle count-advance pulse
//   cnt_enable out  1  counter enable (RUN only)
//   cnt_reset  out  1  counter clear (IDLE only)
//   run_led    out  1  high while counting
//   alarm      out  1  high in DONE (59:59 reached)
//
// Optional feature, macro STOPWATCH_LAP_EN:
//   btn_lap    in   1  raw lap button
//   disp_sec_unit, disp_sec_tens, disp_min_unit, disp_min_tens  out  4 each
//   The disp_* registers follow the count inputs unless a lap hold is active;
//   a lap press in RUN or PAUSE toggles the hold, IDLE releases it.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk_50mhz,
  input  logic       reset_n,
  input  logic       btn_start,
  input  logic       btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       btn_lap,
  output logic [3:0] disp_sec_unit,
  output logic [3:0] disp_sec_tens,
  output logic [3:0] disp_min_unit,
  output logic [3:0] disp_min_tens,
`endif
  input  logic [3:0] sec_unit,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_unit,
  input  logic [3:0] min_tens,
  output logic       tick_1hz,
  output logic       cnt_enable,
  output logic       cnt_reset,
  output logic       run_led,
  output logic       alarm
);

  localparam int PRESC_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ - 1);

  logic start_press;
  logic clear_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk     (clk_50mhz),
    .rst_n   (reset_n),
    .btn_raw (btn_start),
    .press   (start_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk     (clk_50mhz),
    .rst_n   (reset_n),
    .btn_raw (btn_clear),
    .press   (clear_press)
  );

  state_e               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 tick_q, tick_d;
  logic                 cnt_enable_q, cnt_enable_d;
  logic                 cnt_reset_q, cnt_reset_d;
  logic                 run_led_q, run_led_d;
  logic                 alarm_q, alarm_d;
  logic                 tick_due;
  logic                 limit;

  assign tick_due = (presc_q == PRESC_LAST);
  assign limit    = at_limit(sec_unit, sec_tens, min_unit, min_tens);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (clear_press) begin
      // Clear overrides a start press or a due tick in the same cycle.
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          if (start_press) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick_due) begin
            presc_d = '0;
            if (limit) begin
              // At 59:59 the advance is swallowed and the watch stops.
              state_d = ST_DONE;
            end else begin
              // A stop press on a tick cycle still lets that tick out.
              tick_d = 1'b1;
              if (start_press) state_d = ST_PAUSE;
            end
          end else begin
            presc_d = presc_q + 1'b1;
            if (start_press) state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          // Prescaler holds so the partial second resumes after RUN.
          if (start_press) state_d = ST_RUN;
        end
        ST_DONE: begin
          presc_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    cnt_enable_d = (state_d == ST_RUN);
    run_led_d    = (state_d == ST_RUN);
    cnt_reset_d  = (state_d == ST_IDLE);
    alarm_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      tick_q       <= 1'b0;
      cnt_enable_q <= 1'b0;
      cnt_reset_q  <= 1'b1;
      run_led_q    <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      cnt_enable_q <= cnt_enable_d;
      cnt_reset_q  <= cnt_reset_d;
      run_led_q    <= run_led_d;
      alarm_q      <= alarm_d;
    end
  end

  assign tick_1hz   = tick_q;
  assign cnt_enable = cnt_enable_q;
  assign cnt_reset  = cnt_reset_q;
  assign run_led    = run_led_q;
  assign alarm      = alarm_q;

`ifdef STOPWATCH_LAP_EN
  logic        lap_press;
  logic        lap_hold_q, lap_hold_d;
  // Digits packed as {min_tens, min_unit, sec_tens, sec_unit}.
  logic [15:0] disp_q, disp_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_db (
    .clk     (clk_50mhz),
    .rst_n   (reset_n),
    .btn_raw (btn_lap),
    .press   (lap_press)
  );

  always_comb begin
    lap_hold_d = lap_hold_q;
    if (state_d == ST_IDLE) begin
      lap_hold_d = 1'b0;
    end else if (lap_press && ((state_q == ST_RUN) || (state_q == ST_PAUSE))) begin
      lap_hold_d = ~lap_hold_q;
    end
    disp_d = lap_hold_q ? disp_q : {min_tens, min_unit, sec_tens, sec_unit};
  end

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      lap_hold_q <= 1'b0;
      disp_q     <= '0;
    end else begin
      lap_hold_q <= lap_hold_d;
      disp_q     <= disp_d;
    end
  end

  assign disp_min_tens = disp_q[15:12];
  assign disp_min_unit = disp_q[11:8];
  assign disp_sec_tens = disp_q[7:4];
  assign disp_sec_unit = disp_q[3:0];
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Scoreboard bench for stopwatch_ctrl with CLK_FREQ=10, DEBOUNCE_CYCLES=4.
// The stimulus process drives buttons and count inputs, advances a reference
// model of the stopwatch once per clock edge and pushes the expected output
// vector {tick_1hz, cnt_enable, cnt_reset, run_led, alarm} into a queue. A
// separate monitor pops one entry per falling edge and compares it with the
// DUT. The model treats each clean button edge as a press event landing
// DEBOUNCE_CYCLES+3 edges later and counts elapsed RUN cycles to place ticks.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int CLK_FREQ = 10;
  localparam int DEB      = 4;
  localparam int LAT      = DEB + 3;

  logic       clk_50mhz = 1'b0;
  logic       reset_n   = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] sec_unit  = 4'd0;
  logic [3:0] sec_tens  = 4'd0;
  logic [3:0] min_unit  = 4'd0;
  logic [3:0] min_tens  = 4'd0;
  logic       tick_1hz, cnt_enable, cnt_reset, run_led, alarm;
`ifdef STOPWATCH_LAP_EN
  logic       btn_lap = 1'b0;
  logic [3:0] disp_sec_unit, disp_sec_tens, disp_min_unit, disp_min_tens;
`endif

  stopwatch_ctrl #(.CLK_FREQ(CLK_FREQ), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_50mhz     (clk_50mhz),
    .reset_n       (reset_n),
    .btn_start     (btn_start),
    .btn_clear     (btn_clear),
`ifdef STOPWATCH_LAP_EN
    .btn_lap       (btn_lap),
    .disp_sec_unit (disp_sec_unit),
    .disp_sec_tens (disp_sec_tens),
    .disp_min_unit (disp_min_unit),
    .disp_min_tens (disp_min_tens),
`endif
    .sec_unit      (sec_unit),
    .sec_tens      (sec_tens),
    .min_unit      (min_unit),
    .min_tens      (min_tens),
    .tick_1hz      (tick_1hz),
    .cnt_enable    (cnt_enable),
    .cnt_reset     (cnt_reset),
    .run_led       (run_led),
    .alarm         (alarm)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;

  mode_t      mode       = M_IDLE;
  int         run_cycles = 0;
  int         cyc        = 0;
  bit         start_at[int];
  bit         clear_at[int];
  logic [4:0] exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [4:0] mon_exp, mon_act;

  function automatic logic [4:0] outs_for(input mode_t m, input bit t);
    return {t, m == M_RUN, m == M_IDLE, m == M_RUN, m == M_DONE};
  endfunction

  // One clock edge of the reference stopwatch.
  task automatic model_edge();
    bit s, c, t, at59;
    s = start_at.exists(cyc);
    c = clear_at.exists(cyc);
    if (s) start_at.delete(cyc);
    if (c) clear_at.delete(cyc);
    at59 = (min_tens == 4'd5) && (min_unit == 4'd9) &&
           (sec_tens == 4'd5) && (sec_unit == 4'd9);
    t = 1'b0;
    if (c) begin
      mode       = M_IDLE;
      run_cycles = 0;
    end else begin
      case (mode)
        M_IDLE:  if (s) mode = M_RUN;
        M_RUN: begin
          run_cycles++;
          if ((run_cycles % CLK_FREQ == 0) && at59) begin
            mode = M_DONE;
          end else begin
            t = (run_cycles % CLK_FREQ == 0);
            if (s) mode = M_PAUSE;
          end
        end
        M_PAUSE: if (s) mode = M_RUN;
        default: ;
      endcase
    end
    exp_q.push_back(outs_for(mode, t));
  endtask

  task automatic model_reset();
    mode       = M_IDLE;
    run_cycles = 0;
    start_at.delete();
    clear_at.delete();
    exp_q.push_back(outs_for(M_IDLE, 1'b0));
  endtask

  // Advance one clock: model the edge, then return at the falling edge.
  task automatic step();
    @(posedge clk_50mhz);
    cyc++;
    if (!reset_n) model_reset();
    else          model_edge();
    @(negedge clk_50mhz);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic press_btn(input bit s, input bit c, input int width);
    if (s) begin btn_start = 1'b1; start_at[cyc + LAT] = 1'b1; end
    if (c) begin btn_clear = 1'b1; clear_at[cyc + LAT] = 1'b1; end
    repeat (width) step();
    btn_start = 1'b0;
    btn_clear = 1'b0;
    repeat (DEB + 4) step();
  endtask

  // Too short to be accepted: no press event is expected.
  task automatic glitch(input bit on_clear, input int width);
    if (on_clear) btn_clear = 1'b1;
    else          btn_start = 1'b1;
    repeat (width) step();
    btn_start = 1'b0;
    btn_clear = 1'b0;
    repeat (DEB + 4) step();
  endtask

  task automatic set_counts(input logic [3:0] mt, input logic [3:0] mu,
                            input logic [3:0] st, input logic [3:0] su);
    min_tens = mt;
    min_unit = mu;
    sec_tens = st;
    sec_unit = su;
  endtask

  task automatic reset_mid_run();
    @(posedge clk_50mhz);
    cyc++;
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({tick_1hz, cnt_enable, cnt_reset, run_led, alarm} !== 5'b00100) begin
      miscompares++;
      $display("FAIL reset_immediate got(tick,en,clr,led,alarm)=%b expected=00100",
               {tick_1hz, cnt_enable, cnt_reset, run_led, alarm});
    end
    model_reset();
    @(negedge clk_50mhz);
    repeat (3) step();
    reset_n = 1'b1;
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic lap_check();
    set_counts(4'd1, 4'd2, 4'd3, 4'd4);
    btn_lap = 1'b1;
    repeat (DEB + 1) step();
    btn_lap = 1'b0;
    repeat (DEB + 4) step();
    set_counts(4'd2, 4'd3, 4'd4, 4'd5);
    repeat (3) step();
    vectors++;
    if ({disp_min_tens, disp_min_unit, disp_sec_tens, disp_sec_unit} !== 16'h1234) begin
      miscompares++;
      $display("FAIL lap_hold got=%h expected=1234",
               {disp_min_tens, disp_min_unit, disp_sec_tens, disp_sec_unit});
    end
    btn_lap = 1'b1;
    repeat (DEB + 1) step();
    btn_lap = 1'b0;
    repeat (DEB + 4) step();
    vectors++;
    if ({disp_min_tens, disp_min_unit, disp_sec_tens, disp_sec_unit} !== 16'h2345) begin
      miscompares++;
      $display("FAIL lap_release got=%h expected=2345",
               {disp_min_tens, disp_min_unit, disp_sec_tens, disp_sec_unit});
    end
  endtask
`endif

  // Monitor: one expected vector per clock, compared away from the edge.
  always @(negedge clk_50mhz) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {tick_1hz, cnt_enable, cnt_reset, run_led, alarm};
      vectors++;
      if (mon_act !== mon_exp) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d got(tick,en,clr,led,alarm)=%b expected=%b",
                 cyc, mon_act, mon_exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;

    // Quiet after reset, then a glitch that must not start the watch.
    idle(100);
    glitch(1'b0, 2);

    // Start, stop mid-second, resume: partial second carries over.
    press_btn(1'b1, 1'b0, 6);
    idle(5);
    press_btn(1'b1, 1'b0, 6);
    idle(12);
    press_btn(1'b1, 1'b0, 6);
    idle(25);

`ifdef STOPWATCH_LAP_EN
    lap_check();
`endif

    // Run into 59:59, ignored start in DONE, clear back to IDLE.
    set_counts(4'd5, 4'd9, 4'd5, 4'd9);
    idle(15);
    press_btn(1'b1, 1'b0, 5);
    press_btn(1'b0, 1'b1, 5);
    set_counts(4'd0, 4'd0, 4'd0, 4'd0);

    // Start then pause, then start and clear together.
    press_btn(1'b1, 1'b0, 5);
    press_btn(1'b1, 1'b0, 5);
    press_btn(1'b1, 1'b1, 5);

    // Reset in the middle of RUN.
    press_btn(1'b1, 1'b0, 6);
    idle(13);
    reset_mid_run();
    idle(5);

    // Randomized operation mix.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 11))
        0, 1, 2: press_btn(1'b1, 1'b0, $urandom_range(DEB, DEB + 3));
        3:       press_btn(1'b0, 1'b1, $urandom_range(DEB, DEB + 3));
        4:       press_btn(1'b1, 1'b1, $urandom_range(DEB, DEB + 3));
        5:       glitch($urandom_range(0, 1) == 1, $urandom_range(1, DEB - 1));
        6:       begin set_counts(4'd5, 4'd9, 4'd5, 4'd9); idle($urandom_range(1, 20)); end
        7:       begin set_counts(4'd5, 4'd9, 4'd5, 4'd8); idle($urandom_range(1, 20)); end
        8, 9:    begin
                   set_counts(4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                              4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)));
                   idle($urandom_range(1, 25));
                 end
        10:      idle($urandom_range(1, 30));
        default: begin
                   if ($urandom_range(0, 3) == 0) reset_mid_run();
                   else idle($urandom_range(1, 10));
                 end
      endcase
    end

    repeat (2) @(negedge clk_50mhz);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
